// File: rtl/mem_arbiter.sv
// Arbitrates one shared block memory between an I-cache and a D-cache.
// One command outstanding at a time; round-robin on contention, D-cache write wins over read.
module mem_arbiter (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         i_mem_read,
  input  logic [27:0]  i_mem_addr,
  output logic [127:0] i_mem_rdata,
  output logic         i_mem_ready,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic [27:0]  d_mem_addr,
  input  logic [127:0] d_mem_wdata,
  output logic [127:0] d_mem_rdata,
  output logic         d_mem_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;
  logic           op_q, op_d;
  logic [27:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [127:0]   rdata_q, rdata_d;
  logic           i_req, d_req, grant_to_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    i_req        = i_mem_read;
    d_req        = d_mem_read | d_mem_write;
    grant_to_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On contention the side that did not win last time goes first.
          grant_to_d   = (i_req && d_req) ? ~last_grant_q : d_req;
          state_d      = BUSY;
          owner_d      = grant_to_d;
          last_grant_d = grant_to_d;
          op_d         = grant_to_d & d_mem_write;
          addr_d       = grant_to_d ? d_mem_addr : i_mem_addr;
          wdata_d      = grant_to_d ? d_mem_wdata : 128'd0;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      op_q         <= 1'b0;
      addr_q       <= 28'd0;
      wdata_q      <= 128'd0;
      rdata_q      <= 128'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_read    = (state_q == BUSY) && !op_q;
  assign mem_write   = (state_q == BUSY) &&  op_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_mem_ready = (state_q == RESP) && !owner_q;
  assign d_mem_ready = (state_q == RESP) &&  owner_q;
  assign i_mem_rdata = rdata_q;
  assign d_mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table for the named scenarios, then
// randomized cache/memory traffic checked against a transaction-level model.
module tb_mem_arbiter;

  logic         clk;
  logic         proc_reset;
  logic         i_mem_read;
  logic [27:0]  i_mem_addr;
  logic [127:0] i_mem_rdata;
  logic         i_mem_ready;
  logic         d_mem_read, d_mem_write;
  logic [27:0]  d_mem_addr;
  logic [127:0] d_mem_wdata;
  logic [127:0] d_mem_rdata;
  logic         d_mem_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  mem_arbiter dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] Z  = 128'd0;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] B7 = {16{8'hB7}};
  localparam logic [127:0] W1 = {8{16'h1234}};

  // Inputs applied before an edge, expected outputs seen just after it.
  typedef struct {
    logic rst, ir, dr, dw, mr;
    logic [27:0] ia, da;
    logic [127:0] dwd, mrd;
    logic e_mr, e_mw, e_ir, e_dr;
    logic [27:0] e_ma;
    logic [127:0] e_mwd, e_rd;
  } vec_t;

  localparam int NV = 39;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic ir, input logic [27:0] ia,
                              input logic dr, input logic dw, input logic [27:0] da,
                              input logic [127:0] dwd, input logic mr, input logic [127:0] mrd,
                              input logic e_mr, input logic e_mw, input logic [27:0] e_ma,
                              input logic [127:0] e_mwd, input logic e_ir, input logic e_dr,
                              input logic [127:0] e_rd);
    vec_t v;
    v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.mr = mr; v.mrd = mrd; v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma; v.e_mwd = e_mwd;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic emr, input logic emw, input logic [27:0] ema,
                       input logic [127:0] emwd, input logic eir, input logic edr,
                       input logic [127:0] erd);
    n_vec++;
    if ({mem_read, mem_write, mem_addr, mem_wdata, i_mem_ready, d_mem_ready, i_mem_rdata, d_mem_rdata}
        !== {emr, emw, ema, emwd, eir, edr, erd, erd}) begin
      n_err++;
      $display("FAIL %s[%0d]: got rd=%b wr=%b addr=%h wdata=%h irdy=%b drdy=%b irdata=%h drdata=%h | want rd=%b wr=%b addr=%h wdata=%h irdy=%b drdy=%b rdata=%h",
               name, idx, mem_read, mem_write, mem_addr, mem_wdata, i_mem_ready, d_mem_ready,
               i_mem_rdata, d_mem_rdata, emr, emw, ema, emwd, eir, edr, erd);
    end
  endtask

  // Reference model: one in-flight transaction record plus a pending-pulse flag.
  logic         m_cmd_live = 1'b0;
  logic         m_pulse    = 1'b0;
  logic         m_owner_d  = 1'b0;
  logic         m_is_write = 1'b0;
  logic         m_last_d   = 1'b0;
  logic [27:0]  m_addr     = 28'd0;
  logic [127:0] m_wdata    = Z;
  logic [127:0] m_rdata    = Z;

  task automatic model_step();
    logic want_i, want_d, pick_d;
    want_i = i_mem_read;
    want_d = d_mem_read | d_mem_write;
    if (proc_reset) begin
      m_cmd_live = 0; m_pulse = 0; m_owner_d = 0; m_is_write = 0; m_last_d = 0;
      m_addr = 28'd0; m_wdata = Z; m_rdata = Z;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (m_cmd_live) begin
      if (mem_ready) begin
        m_rdata = mem_rdata; m_cmd_live = 0; m_pulse = 1;
        n_txn++;
        $display("txn %0d: %s %s addr=%h", n_txn, m_owner_d ? "D" : "I",
                 m_is_write ? "write" : "read", m_addr);
      end
    end else if (want_i || want_d) begin
      pick_d     = (want_i && want_d) ? !m_last_d : want_d;
      m_last_d   = pick_d;
      m_owner_d  = pick_d;
      m_is_write = pick_d && d_mem_write;
      m_addr     = pick_d ? d_mem_addr : i_mem_addr;
      m_wdata    = pick_d ? d_mem_wdata : Z;
      m_cmd_live = 1;
    end
  endtask

  task automatic drive_random();
    proc_reset = ($urandom_range(0, 99) == 0);
    if (i_mem_ready || (i_mem_read && $urandom_range(0, 39) == 0)) i_mem_read = 1'b0;
    else if (!i_mem_read && $urandom_range(0, 2) == 0) begin
      i_mem_read = 1'b1;
      i_mem_addr = 28'($urandom);
    end
    if (d_mem_ready || ((d_mem_read || d_mem_write) && $urandom_range(0, 39) == 0)) begin
      d_mem_read = 1'b0; d_mem_write = 1'b0;
    end else if (!(d_mem_read || d_mem_write) && $urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 2))
        0:       begin d_mem_read = 1'b1; d_mem_write = 1'b0; end
        1:       begin d_mem_read = 1'b0; d_mem_write = 1'b1; end
        default: begin d_mem_read = 1'b1; d_mem_write = 1'b1; end
      endcase
      d_mem_addr  = 28'($urandom);
      d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    mem_ready = ($urandom_range(0, 3) == 0);
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    //                rst ir ia         dr dw da           dwd mr mrd | mr mw ma           mwd irdy drdy rdata
    tbl[0]  = mk(1, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h0,       Z,  0, 0, Z);
    tbl[1]  = mk(1, 1, 28'h10,     0, 0, 28'h0,       Z,  1, A5,  0, 0, 28'h0,       Z,  0, 0, Z);
    tbl[2]  = mk(0, 1, 28'h10,     0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h10,      Z,  0, 0, Z);
    tbl[3]  = mk(0, 1, 28'h10,     0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h10,      Z,  0, 0, Z);
    tbl[4]  = mk(0, 1, 28'h10,     0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h10,      Z,  0, 0, Z);
    tbl[5]  = mk(0, 1, 28'h10,     0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h10,      Z,  0, 0, Z);
    tbl[6]  = mk(0, 1, 28'h10,     0, 0, 28'h0,       Z,  1, A5,  0, 0, 28'h10,      Z,  1, 0, A5);
    tbl[7]  = mk(0, 1, 28'h10,     0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h10,      Z,  0, 0, A5);
    tbl[8]  = mk(0, 0, 28'h0,      0, 1, 28'hABCDEF,  W1, 0, Z,   0, 1, 28'hABCDEF,  W1, 0, 0, A5);
    tbl[9]  = mk(0, 0, 28'h0,      0, 1, 28'hABCDEF,  W1, 1, B7,  0, 0, 28'hABCDEF,  W1, 0, 1, B7);
    tbl[10] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'hABCDEF,  W1, 0, 0, B7);
    tbl[11] = mk(1, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h0,       Z,  0, 0, Z);
    tbl[12] = mk(0, 1, 28'h111,    1, 0, 28'h222,     Z,  0, Z,   1, 0, 28'h222,     Z,  0, 0, Z);
    tbl[13] = mk(0, 1, 28'h111,    1, 0, 28'h222,     Z,  1, A5,  0, 0, 28'h222,     Z,  0, 1, A5);
    tbl[14] = mk(0, 1, 28'h111,    1, 0, 28'h333,     Z,  0, Z,   0, 0, 28'h222,     Z,  0, 0, A5);
    tbl[15] = mk(0, 1, 28'h111,    1, 0, 28'h333,     Z,  0, Z,   1, 0, 28'h111,     Z,  0, 0, A5);
    tbl[16] = mk(0, 1, 28'h111,    1, 0, 28'h333,     Z,  1, B7,  0, 0, 28'h111,     Z,  1, 0, B7);
    tbl[17] = mk(0, 0, 28'h0,      1, 0, 28'h333,     Z,  0, Z,   0, 0, 28'h111,     Z,  0, 0, B7);
    tbl[18] = mk(0, 0, 28'h0,      1, 0, 28'h333,     Z,  0, Z,   1, 0, 28'h333,     Z,  0, 0, B7);
    tbl[19] = mk(0, 0, 28'h0,      1, 0, 28'h333,     Z,  1, A5,  0, 0, 28'h333,     Z,  0, 1, A5);
    tbl[20] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h333,     Z,  0, 0, A5);
    tbl[21] = mk(0, 0, 28'h0,      1, 1, 28'h444,     W1, 0, Z,   0, 1, 28'h444,     W1, 0, 0, A5);
    tbl[22] = mk(0, 0, 28'h0,      1, 1, 28'h444,     W1, 1, Z,   0, 0, 28'h444,     W1, 0, 1, Z);
    tbl[23] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h444,     W1, 0, 0, Z);
    tbl[24] = mk(0, 1, 28'h555,    0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h555,     Z,  0, 0, Z);
    tbl[25] = mk(1, 1, 28'h555,    0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h0,       Z,  0, 0, Z);
    tbl[26] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  1, A5,  0, 0, 28'h0,       Z,  0, 0, Z);
    tbl[27] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h0,       Z,  0, 0, Z);
    tbl[28] = mk(0, 1, 28'h666,    0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h666,     Z,  0, 0, Z);
    tbl[29] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h666,     Z,  0, 0, Z);
    tbl[30] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h666,     Z,  0, 0, Z);
    tbl[31] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  1, B7,  0, 0, 28'h666,     Z,  1, 0, B7);
    tbl[32] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h666,     Z,  0, 0, B7);
    tbl[33] = mk(0, 1, 28'h777,    1, 1, 28'h888,     W1, 0, Z,   0, 1, 28'h888,     W1, 0, 0, B7);
    tbl[34] = mk(0, 1, 28'h777,    1, 1, 28'h888,     W1, 1, A5,  0, 0, 28'h888,     W1, 0, 1, A5);
    tbl[35] = mk(0, 1, 28'h777,    0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h888,     W1, 0, 0, A5);
    tbl[36] = mk(0, 1, 28'h777,    0, 0, 28'h0,       Z,  0, Z,   1, 0, 28'h777,     Z,  0, 0, A5);
    tbl[37] = mk(0, 1, 28'h777,    0, 0, 28'h0,       Z,  1, B7,  0, 0, 28'h777,     Z,  1, 0, B7);
    tbl[38] = mk(0, 0, 28'h0,      0, 0, 28'h0,       Z,  0, Z,   0, 0, 28'h777,     Z,  0, 0, B7);

    for (int k = 0; k < NV; k++) begin
      proc_reset  = tbl[k].rst;
      i_mem_read  = tbl[k].ir;
      i_mem_addr  = tbl[k].ia;
      d_mem_read  = tbl[k].dr;
      d_mem_write = tbl[k].dw;
      d_mem_addr  = tbl[k].da;
      d_mem_wdata = tbl[k].dwd;
      mem_ready   = tbl[k].mr;
      mem_rdata   = tbl[k].mrd;
      @(posedge clk);
      #1;
      check("vec", k, tbl[k].e_mr, tbl[k].e_mw, tbl[k].e_ma, tbl[k].e_mwd,
            tbl[k].e_ir, tbl[k].e_dr, tbl[k].e_rd);
      $display("vec %0d applied: rd=%b wr=%b addr=%h irdy=%b drdy=%b",
               k, mem_read, mem_write, mem_addr, i_mem_ready, d_mem_ready);
    end

    // Randomized traffic; the first edge carries a reset so model and DUT align.
    proc_reset = 1'b1; i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    mem_ready = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      drive_random();
      @(negedge clk);
      check("rand", c, m_cmd_live && !m_is_write, m_cmd_live && m_is_write, m_addr, m_wdata,
            m_pulse && !m_owner_d, m_pulse && m_owner_d, m_rdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port proc_reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port i_mem_read, input, 1 bit: I-cache block-read request; level signal, held until i_mem_ready.
REQ-004 SHALL have port i_mem_addr, input, 28 bits: I-cache block address.
REQ-005 SHALL have port i_mem_rdata, output, 128 bits: read block returned to the I-cache.
REQ-006 SHALL have port i_mem_ready, output, 1 bit: one-cycle completion pulse to the I-cache.
REQ-007 SHALL have ports d_mem_read and d_mem_write, inputs, 1 bit each: D-cache block read and write requests; level signals, held until d_mem_ready.
REQ-008 SHALL have port d_mem_addr, input, 28 bits: D-cache block address.
REQ-009 SHALL have port d_mem_wdata, input, 128 bits: D-cache write block.
REQ-010 SHALL have port d_mem_rdata, output, 128 bits: read block returned to the D-cache.
REQ-011 SHALL have port d_mem_ready, output, 1 bit: one-cycle completion pulse to the D-cache.
REQ-012 SHALL have ports mem_read and mem_write, outputs, 1 bit each: commands to the shared memory.
REQ-013 SHALL have port mem_addr, output, 28 bits: block address to the shared memory.
REQ-014 SHALL have port mem_wdata, output, 128 bits: write data to the shared memory.
REQ-015 SHALL have port mem_rdata, input, 128 bits: read data from the shared memory, valid while mem_ready is 1.
REQ-016 SHALL have port mem_ready, input, 1 bit: completion of the current memory command.

Function
REQ-017 SHALL implement an FSM with three states.
- IDLE: samples requests.
- BUSY: a memory command is outstanding.
- RESP: the completion pulse is driven.
REQ-018 IDLE: if no request is active, SHALL stay in IDLE; otherwise SHALL grant one requester, move to BUSY and register the command.
- owner register: 0 = I-cache, 1 = D-cache.
- op register.
- addr register: 28 bits.
- wdata register: 128 bits.
REQ-019 Contention is I and D requests active in the same IDLE cycle. It SHALL be resolved round-robin against a last_grant bit: grant goes to the requester not granted last time. Without contention, the single requester is granted.
REQ-020 last_grant SHALL update to the granted owner at every grant.
REQ-021 If D asserts read and write together, the op SHALL be a write.
REQ-022 For an I-cache grant, mem_wdata SHALL be 0.
REQ-023 BUSY: mem_read or mem_write (per the registered op), mem_addr and mem_wdata SHALL be driven from registers and held stable. This SHALL continue until mem_ready=1, even if the requester deasserts meanwhile.
REQ-024 BUSY with mem_ready=1:
- mem_rdata SHALL be captured into a 128-bit rdata register.
- The FSM SHALL move to RESP.
- mem_read and mem_write SHALL be 0 from the next cycle.
REQ-025 RESP (exactly one cycle):
- The owner's ready output SHALL be 1.
- The other ready output SHALL be 0.
- Requests SHALL NOT be sampled.
- Next state is IDLE unconditionally.
REQ-026 i_mem_rdata and d_mem_rdata SHALL both be driven from the rdata register. Each is meaningful only while its ready output is 1.
REQ-027 Timing: grant decided in IDLE at cycle T drives the memory command from T+1. mem_ready at cycle M gives the ready pulse at M+1. A new grant is possible at M+2 at the earliest.
REQ-028 At most one memory command SHALL be outstanding. mem_read and mem_write SHALL never both be 1.
REQ-029 A request that is not granted SHALL wait; it is neither dropped nor reordered. Round-robin bounds the wait to one transaction of the other cache.

Reset
REQ-030 proc_reset=1 at a rising edge SHALL force the following, taking effect that edge:
- FSM to IDLE.
- last_grant to 0 (I-cache), so the first contention grants the D-cache.
- owner, op, addr, wdata and rdata registers to 0.
REQ-031 During and after reset, all outputs SHALL be 0 until the first grant: mem_read, mem_write, mem_addr, mem_wdata, i_mem_ready, d_mem_ready, i_mem_rdata, d_mem_rdata.
REQ-032 Reset in BUSY or RESP SHALL abort the transaction. No ready pulse is issued, and a late mem_ready in IDLE SHALL be ignored.

Verification
REQ-033 Scenario, lone I read: i_mem_read=1, i_mem_addr=0x0000010, memory ready after 4 cycles with mem_rdata=0xA5..A5.
- mem_read=1 with mem_addr=0x0000010 from the cycle after the request.
- i_mem_ready pulses 1 cycle with i_mem_rdata=0xA5..A5.
- d_mem_ready stays 0.
REQ-034 Scenario, lone D write: d_mem_write=1, d_mem_addr=0x0ABCDEF, d_mem_wdata=0x1234..
- mem_write=1 with matching addr/wdata and mem_read=0 until mem_ready.
- Then a single d_mem_ready pulse.
REQ-035 Scenario, contention after reset: I and D request together.
- D is served first.
- I is then granted in the IDLE cycle after D's RESP.
- On the next simultaneous request, I is served first.
REQ-036 Scenario, D read+write both 1: the command issues as mem_write=1, mem_read=0.
REQ-037 Scenario, reset mid-BUSY: proc_reset asserted in BUSY.
- Next cycle: IDLE, mem_read=mem_write=0.
- A following mem_ready=1 produces no ready pulse.
REQ-038 Scenario, requester drops in BUSY: I request dropped while in BUSY.
- mem_read is held until mem_ready.
- The i_mem_ready pulse is still issued.
